// File: rtl/spi_ram_arbiter.sv
// Decodes SPI command words and shares one RAM port with a parallel host port.
// Define ARB_FIXED_PRIO_EN to give SPI fixed priority instead of round-robin.
module spi_ram_arbiter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_cmd_valid,
    input  logic [DATA_WIDTH+1:0] spi_cmd,
    output logic                  spi_cmd_ready,
    output logic                  spi_rd_valid,
    output logic [DATA_WIDTH-1:0] spi_rd_data,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_gnt,
    output logic                  host_rd_valid,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    typedef enum logic [1:0] {ARB_IDLE, ARB_SPI_GRANT, ARB_HOST_GRANT} arb_state_e;
    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } spi_op_e;
    typedef enum logic {OWN_SPI = 1'b0, OWN_HOST = 1'b1} owner_e;

    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return (a == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic                  pend_valid_q, pend_valid_d, pend_we_q, pend_we_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic                  ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    owner_e                acc_owner_q, acc_owner_d, ret_owner_q, ret_owner_d;
    logic                  ret_valid_q, ret_valid_d;
    logic [DATA_WIDTH-1:0] spi_rd_hold_q, spi_rd_hold_d, host_rd_hold_q, host_rd_hold_d;
`ifndef ARB_FIXED_PRIO_EN
    owner_e                last_winner_q, last_winner_d;
`endif

    arb_state_e            arb_state;
    logic                  spi_gnt;
    spi_op_e               spi_op;
    logic [DATA_WIDTH-1:0] spi_payload;

    assign spi_op      = spi_op_e'(spi_cmd[DATA_WIDTH+1:DATA_WIDTH]);
    assign spi_payload = spi_cmd[DATA_WIDTH-1:0];

    always_comb begin
        arb_state = ARB_IDLE;
        if (pend_valid_q && host_req) begin
`ifdef ARB_FIXED_PRIO_EN
            arb_state = ARB_SPI_GRANT;
`else
            arb_state = (last_winner_q == OWN_HOST) ? ARB_SPI_GRANT : ARB_HOST_GRANT;
`endif
        end else if (pend_valid_q) begin
            arb_state = ARB_SPI_GRANT;
        end else if (host_req) begin
            arb_state = ARB_HOST_GRANT;
        end
    end

    assign spi_gnt  = (arb_state == ARB_SPI_GRANT);
    assign host_gnt = (arb_state == ARB_HOST_GRANT);

`ifndef ARB_FIXED_PRIO_EN
    always_comb begin
        last_winner_d = last_winner_q;
        if (pend_valid_q && host_req) begin
            last_winner_d = host_gnt ? OWN_HOST : OWN_SPI;
        end
    end
`endif

    // Accept and grant are mutually exclusive: accept needs pend empty, grant needs it full.
    always_comb begin
        spi_cmd_ready = !pend_valid_q;
        wr_addr_d     = wr_addr_q;
        rd_addr_d     = rd_addr_q;
        pend_valid_d  = pend_valid_q;
        pend_we_d     = pend_we_q;
        pend_addr_d   = pend_addr_q;
        pend_data_d   = pend_data_q;
        if (spi_gnt) begin
            pend_valid_d = 1'b0;
        end
        if (spi_cmd_valid && spi_cmd_ready) begin
            unique case (spi_op)
                OP_WR_ADDR: wr_addr_d = ADDR_WIDTH'(spi_payload);
                OP_WR_DATA: begin
                    pend_valid_d = 1'b1;
                    pend_we_d    = 1'b1;
                    pend_addr_d  = wr_addr_q;
                    pend_data_d  = spi_payload;
                    wr_addr_d    = addr_inc(wr_addr_q);
                end
                OP_RD_ADDR: rd_addr_d = ADDR_WIDTH'(spi_payload);
                OP_RD_DATA: begin
                    pend_valid_d = 1'b1;
                    pend_we_d    = 1'b0;
                    pend_addr_d  = rd_addr_q;
                    rd_addr_d    = addr_inc(rd_addr_q);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_en_d    = spi_gnt || host_gnt;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        acc_owner_d = acc_owner_q;
        if (spi_gnt) begin
            ram_we_d    = pend_we_q;
            ram_addr_d  = pend_addr_q;
            ram_wdata_d = pend_data_q;
            acc_owner_d = OWN_SPI;
        end else if (host_gnt) begin
            ram_we_d    = host_we;
            ram_addr_d  = host_addr;
            ram_wdata_d = host_wdata;
            acc_owner_d = OWN_HOST;
        end
    end

    // Read data is routed straight from the RAM in the return cycle; the hold regs cover the gaps.
    always_comb begin
        ret_valid_d    = ram_en_q && !ram_we_q;
        ret_owner_d    = acc_owner_q;
        spi_rd_valid   = ret_valid_q && (ret_owner_q == OWN_SPI);
        host_rd_valid  = ret_valid_q && (ret_owner_q == OWN_HOST);
        spi_rd_data    = spi_rd_valid ? ram_rdata : spi_rd_hold_q;
        host_rd_data   = host_rd_valid ? ram_rdata : host_rd_hold_q;
        spi_rd_hold_d  = spi_rd_data;
        host_rd_hold_d = host_rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            pend_valid_q   <= 1'b0;
            pend_we_q      <= 1'b0;
            pend_addr_q    <= '0;
            pend_data_q    <= '0;
            ram_en_q       <= 1'b0;
            ram_we_q       <= 1'b0;
            ram_addr_q     <= '0;
            ram_wdata_q    <= '0;
            acc_owner_q    <= OWN_SPI;
            ret_valid_q    <= 1'b0;
            ret_owner_q    <= OWN_SPI;
            spi_rd_hold_q  <= '0;
            host_rd_hold_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_winner_q  <= OWN_HOST;
`endif
        end else begin
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            pend_valid_q   <= pend_valid_d;
            pend_we_q      <= pend_we_d;
            pend_addr_q    <= pend_addr_d;
            pend_data_q    <= pend_data_d;
            ram_en_q       <= ram_en_d;
            ram_we_q       <= ram_we_d;
            ram_addr_q     <= ram_addr_d;
            ram_wdata_q    <= ram_wdata_d;
            acc_owner_q    <= acc_owner_d;
            ret_valid_q    <= ret_valid_d;
            ret_owner_q    <= ret_owner_d;
            spi_rd_hold_q  <= spi_rd_hold_d;
            host_rd_hold_q <= host_rd_hold_d;
`ifndef ARB_FIXED_PRIO_EN
            last_winner_q  <= last_winner_d;
`endif
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Randomized self-checking bench for spi_ram_arbiter against a transaction-level
// reference model (golden memory, request queue, round-robin turn bit).
module tb_spi_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       spi_cmd_valid = 1'b0;
    logic [9:0] spi_cmd = '0;
    logic       spi_cmd_ready, spi_rd_valid;
    logic [7:0] spi_rd_data;
    logic       host_req = 1'b0, host_we = 1'b0;
    logic [7:0] host_addr = '0, host_wdata = '0;
    logic       host_gnt, host_rd_valid;
    logic [7:0] host_rd_data;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    spi_ram_arbiter #(.DATA_WIDTH(8), .MEM_DEPTH(256), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .spi_cmd_valid(spi_cmd_valid), .spi_cmd(spi_cmd), .spi_cmd_ready(spi_cmd_ready),
        .spi_rd_valid(spi_rd_valid), .spi_rd_data(spi_rd_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Single-port RAM with one cycle read latency.
    logic [7:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    int unsigned n_cmp = 0, n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {bit we; logic [7:0] addr; logic [7:0] data;} host_op_t;
    host_op_t   hq[$];
    logic [7:0] gold [256];
    bit         m_pend, m_pend_we, m_last_host;
    logic [7:0] m_pend_addr, m_pend_data, m_wr, m_rd;
    bit         m_en, m_we;
    logic [7:0] m_addr, m_wdata;
    bit         r1_v, r1_host, r2_v, r2_host;
    logic [7:0] r1_d, r2_d, m_spi_hold, m_host_hold;
    int unsigned n_host_pulse, n_spi_pulse;

    task automatic model_reset();
        m_pend = 0; m_pend_we = 0; m_pend_addr = '0; m_pend_data = '0;
        m_wr = '0; m_rd = '0; m_last_host = 1;
        m_en = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        r1_v = 0; r1_host = 0; r1_d = '0; r2_v = 0; r2_host = 0; r2_d = '0;
        m_spi_hold = '0; m_host_hold = '0;
    endtask

    task automatic drive_host();
        if (hq.size() > 0) begin
            host_req = 1; host_we = hq[0].we; host_addr = hq[0].addr; host_wdata = hq[0].data;
        end else begin
            host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        end
    endtask

    // One clock: check DUT against model mid-cycle, then advance the model across the edge.
    task automatic step();
        bit spi_win, host_win, acc, contend;
        logic [9:0] cmd;
        host_op_t h;
        drive_host();
        @(negedge clk);
        acc     = spi_cmd_valid && !m_pend;
        cmd     = spi_cmd;
        contend = m_pend && host_req;
`ifdef ARB_FIXED_PRIO_EN
        spi_win = m_pend;
`else
        spi_win = m_pend && (!host_req || m_last_host);
`endif
        host_win = host_req && !spi_win;
        check_eq("spi_cmd_ready", spi_cmd_ready, !m_pend);
        check_eq("host_gnt", host_gnt, host_win);
        check_eq("ram_en", ram_en, m_en);
        if (m_en) begin
            check_eq("ram_we", ram_we, m_we);
            check_eq("ram_addr", ram_addr, m_addr);
            if (m_we) check_eq("ram_wdata", ram_wdata, m_wdata);
        end
        check_eq("spi_rd_valid", spi_rd_valid, r2_v && !r2_host);
        check_eq("host_rd_valid", host_rd_valid, r2_v && r2_host);
        check_eq("spi_rd_data", spi_rd_data, (r2_v && !r2_host) ? r2_d : m_spi_hold);
        check_eq("host_rd_data", host_rd_data, (r2_v && r2_host) ? r2_d : m_host_hold);
        if (spi_rd_valid) n_spi_pulse++;
        if (host_rd_valid) n_host_pulse++;
        @(posedge clk);
        if (r2_v && !r2_host) m_spi_hold = r2_d;
        if (r2_v && r2_host) m_host_hold = r2_d;
        r2_v = r1_v; r2_host = r1_host; r2_d = r1_d; r1_v = 0;
        if (contend) m_last_host = host_win;
        m_en = spi_win || host_win;
        if (spi_win) begin
            m_we = m_pend_we; m_addr = m_pend_addr; m_wdata = m_pend_data; m_pend = 0;
        end else if (host_win) begin
            h = hq.pop_front();
            m_we = h.we; m_addr = h.addr; m_wdata = h.data;
        end else begin
            m_we = 0;
        end
        if (m_en) begin
            if (m_we) gold[m_addr] = m_wdata;
            else begin r1_v = 1; r1_host = host_win; r1_d = gold[m_addr]; end
        end
        if (acc) begin
            case (cmd[9:8])
                2'b00: m_wr = cmd[7:0];
                2'b01: begin m_pend = 1; m_pend_we = 1; m_pend_addr = m_wr; m_pend_data = cmd[7:0]; m_wr = m_wr + 8'd1; end
                2'b10: m_rd = cmd[7:0];
                default: begin m_pend = 1; m_pend_we = 0; m_pend_addr = m_rd; m_rd = m_rd + 8'd1; end
            endcase
        end
        #1;
    endtask

    task automatic spi_send(input logic [9:0] c);
        bit done = 0;
        spi_cmd_valid = 1; spi_cmd = c;
        for (int unsigned i = 0; i < 8 && !done; i++) begin
            done = !m_pend;
            step();
        end
        spi_cmd_valid = 0;
        check_eq("spi_accept", done, 1);
    endtask

    task automatic do_reset();
        hq.delete();
        drive_host();
        spi_cmd_valid = 0;
        rst = 1;
        #1;
        check_eq("rst_spi_cmd_ready", spi_cmd_ready, 1);
        check_eq("rst_spi_rd_valid", spi_rd_valid, 0);
        check_eq("rst_spi_rd_data", spi_rd_data, 0);
        check_eq("rst_host_gnt", host_gnt, 0);
        check_eq("rst_host_rd_valid", host_rd_valid, 0);
        check_eq("rst_host_rd_data", host_rd_data, 0);
        check_eq("rst_ram_en", ram_en, 0);
        check_eq("rst_ram_we", ram_we, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_ram_wdata", ram_wdata, 0);
        @(negedge clk);
        check_eq("rst_hold_spi_rd_valid", spi_rd_valid, 0);
        check_eq("rst_hold_host_rd_valid", host_rd_valid, 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        logic [7:0] d;
        host_op_t op;
        model_reset();
        #2;
        do_reset();

        // Fill the whole RAM through SPI so every address has a known value.
        spi_send(10'h000);
        for (int unsigned i = 0; i < 256; i++) begin
            d = 8'($urandom);
            spi_send({2'b01, d});
        end
        step(); step();
        do_reset();

        // Write 0xA5 at 0x3C and read it back.
        spi_send(10'h03C); spi_send(10'h1A5); spi_send(10'h23C); spi_send(10'h300);
        step(); step();
        check_eq("t1_rd_valid_lat", spi_rd_valid, 1);
        check_eq("t1_rd_data", spi_rd_data, 8'hA5);
        step();
        check_eq("t1_rd_hold", spi_rd_data, 8'hA5);

        // Write address wrap-around and ready deassertion after data accepts.
        spi_send(10'h0FF);
        spi_send(10'h111);
        check_eq("t2_ready_low1", spi_cmd_ready, 0);
        spi_send(10'h122);
        check_eq("t2_ready_low2", spi_cmd_ready, 0);
        step(); step();

        // Contention right after reset: SPI first, then host on the next contention.
        do_reset();
        spi_send(10'h300);
        op = '{we: 1'b0, addr: 8'h10, data: 8'h00};
        hq.push_back(op);
        drive_host();
        #1;
        check_eq("t3_contend1_host_gnt", host_gnt, 0);
        step(); step(); step();
        spi_send(10'h300);
        op = '{we: 1'b0, addr: 8'h11, data: 8'h00};
        hq.push_back(op);
        drive_host();
        #1;
`ifdef ARB_FIXED_PRIO_EN
        check_eq("t3_contend2_host_gnt", host_gnt, 0);
`else
        check_eq("t3_contend2_host_gnt", host_gnt, 1);
`endif
        step(); step(); step(); step();

        // Host reads 0..3 held continuously while SPI streams writes elsewhere.
        spi_send(10'h000);
        for (int unsigned i = 0; i < 4; i++) spi_send({2'b01, 8'($urandom)});
        step(); step();
        n_host_pulse = 0; n_spi_pulse = 0;
        for (int unsigned i = 0; i < 4; i++) begin
            op = '{we: 1'b0, addr: 8'(i), data: 8'h00};
            hq.push_back(op);
        end
        spi_send(10'h040);
        for (int unsigned i = 0; i < 6; i++) spi_send({2'b01, 8'($urandom)});
        for (int unsigned i = 0; i < 6; i++) step();
        check_eq("t4_host_pulses", n_host_pulse, 4);
        check_eq("t4_spi_pulses", n_spi_pulse, 0);

        // Reset while a read is in flight.
        spi_send(10'h210); spi_send(10'h300);
        step();
        check_eq("t5_inflight_en", ram_en, 1);
        do_reset();
        step();
        spi_send(10'h177);
        step();
        check_eq("t5_wr_addr0", ram_addr, 0);
        check_eq("t5_wr_we", ram_we, 1);
        spi_send(10'h300);
        step();
        check_eq("t5_rd_addr0", ram_addr, 0);
        step();
        check_eq("t5_rd_data", spi_rd_data, 8'h77);

        // Randomized traffic from both sides.
        for (int unsigned i = 0; i < 600; i++) begin
            if (hq.size() < 2 && $urandom_range(0, 2) == 0) begin
                op = '{we: 1'($urandom), addr: 8'($urandom), data: 8'($urandom)};
                hq.push_back(op);
            end
            if ($urandom_range(0, 1) == 1) spi_send(10'($urandom));
            else step();
        end
        for (int unsigned i = 0; i < 6; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_ram_arbiter.md
# spi_ram_arbiter

Sequencing and arbitration controller in front of the single-port RAM (MEM_DEPTH 256 x MEM_WIDTH 8). It decodes the 10-bit command words delivered by the SPI slave: address-load, write-data and read-data. It shares the RAM's single access port between the SPI command path and a parallel host port, issuing at most one RAM access per cycle. Read data is returned to whichever requester issued the read.

## Interface
- DATA_WIDTH, 8, RAM word width and SPI payload width
- MEM_DEPTH, 256, RAM depth in words
- ADDR_WIDTH, 8, RAM address width, equal to log2(MEM_DEPTH)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- spi_cmd_valid  in  1  SPI command word present
- spi_cmd  in  DATA_WIDTH+2  bits [9:8] opcode, bits [7:0] payload
- spi_cmd_ready  out  1  command accepted when valid and ready are both high
- spi_rd_valid  out  1  single-cycle pulse, SPI read data valid
- spi_rd_data  out  DATA_WIDTH  SPI read data
- host_req  in  1  host access request, held until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_WIDTH  host address
- host_wdata  in  DATA_WIDTH  host write data
- host_gnt  out  1  combinational; host request wins this cycle
- host_rd_valid  out  1  single-cycle pulse, host read data valid
- host_rd_data  out  DATA_WIDTH  host read data
- ram_en  out  1  registered RAM access strobe
- ram_we  out  1  registered RAM write enable
- ram_addr  out  ADDR_WIDTH  registered RAM address
- ram_wdata  out  DATA_WIDTH  registered RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_en with ram_we = 0

## Operation
- SPI opcodes:
  - 00: load wr_addr from the payload; no RAM access.
  - 01: write the payload to wr_addr, then increment wr_addr.
  - 10: load rd_addr from the payload; no RAM access.
  - 11: read from rd_addr, then increment rd_addr. The payload is ignored.
- Address increments wrap from MEM_DEPTH-1 to 0.
- Opcodes 01 and 11 are stored in a one-entry pending register (pend_valid, pend_we, pend_addr, pend_data). The address is captured at accept time and the increment is applied at that same edge.
- spi_cmd_ready = !pend_valid. Address opcodes are therefore also stalled while an access is pending, which preserves ordering.
- Arbiter states:
  - IDLE: no request.
  - SPI_GRANT: pend_valid wins.
  - HOST_GRANT: host_req wins.
  - Evaluated every cycle; both the state and the winner are combinational from pend_valid and host_req.
- Contention rule (pend_valid and host_req both high): round-robin. The winner is the requester that did not win the previous contended cycle.
- last_contend_winner resets to HOST, so SPI wins the first contention.
- Uncontended requests always win.
- A winning SPI request clears pend_valid at the edge.
- Read-return pipeline: a tag pipe (valid, owner) follows ram_en. The cycle after a read ram_en, ram_rdata is routed to the owner's rd_data and the owner's rd_valid pulses.
- rd_data outputs hold their last value between pulses.
- Writes produce no return pulse.

## Timing
- Reset values: spi_cmd_ready 1, spi_rd_valid 0, spi_rd_data 0, host_gnt 0, host_rd_valid 0, host_rd_data 0, ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0.
- Reset also clears wr_addr, rd_addr, pend_valid, the tag pipe and last_contend_winner.
- Reset mid-operation discards any pending or in-flight access, and no rd_valid pulse follows.
- SPI access, accepted at edge E0:
  - pend_valid is high after E0.
  - If SPI wins, ram_en is high after E1.
  - For a read, spi_rd_valid is high after E2.
  - Minimum latency is 3 cycles from accept to read data.
  - SPI throughput is at most 1 access per 2 cycles.
- Host access:
  - host_gnt is high in cycle N.
  - ram_en is high in N+1.
  - host_rd_valid is high in N+2.
  - host_req may be held continuously; each granted cycle is one access.
- Under sustained two-sided contention the requesters alternate, and neither waits more than 1 cycle for arbitration.
- A write followed by a read to the same address returns the new data because accesses are strictly serialised.

## Configuration
- ARB_FIXED_PRIO_EN:
  - Defined: pend_valid always beats host_req, and last_contend_winner is not implemented. The host can be starved only while SPI sustains back-to-back accesses, which the ready rule limits to every other cycle.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset, then SPI 0x0_3C, 0x1_A5, 0x2_3C, 0x3_00 -> ram write at 0x3C with data 0xA5; spi_rd_valid pulses with spi_rd_data 0xA5, 3 cycles after the 0x3_00 accept.
- SPI 0x0_FF, 0x1_11, 0x1_22 -> writes at 0xFF then 0x00 (wrap-around); spi_cmd_ready low for the cycle after each data accept.
- Contention: pend_valid and host_req (read 0x10) high in the same cycle right after reset -> SPI granted first and host_gnt in the next cycle; in a second contention, host wins.
- Host holds host_req with reads of 0x00..0x03 while SPI streams writes -> grants alternate; each host_rd_valid carries the correct pre-written data, and no spi_rd_valid is asserted.
- Assert rst while a read ram_en is in flight -> no rd_valid pulse; all outputs return to their reset values immediately; wr_addr and rd_addr are 0 afterwards.
- With ARB_FIXED_PRIO_EN defined, repeat the contention scenario -> SPI wins every contended cycle.
